// File: rtl/conversor_bcd_pkg.sv
// Shared types and sizes for the sequential binary-to-BCD display converter.
// Optional leading-zero blanking is selected with CONVERSOR_BCD_BLANK_EN.
package conversor_bcd_pkg;
  localparam int N_IN  = 32;
  localparam int N_BCD = 10;
  localparam int N_OUT = 4;

  localparam logic [3:0] BLANK_CODE_DEF = 4'hE;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;
endpackage

// File: rtl/conversor_bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD digit of 5 or more before the shift.
// Purely combinational, no latency.
module bcd_add3 (
  input  logic [3:0] i_dig,
  output logic [3:0] o_dig
);
  assign o_dig = (i_dig >= 4'd5) ? (i_dig + 4'd3) : i_dig;
endmodule

// File: rtl/conversor_bcd.sv
// Sequential double-dabble converter: 32-bit value to four display digits, 34 edges load-to-Done.
// Build with CONVERSOR_BCD_BLANK_EN to blank leading-zero digits; a one-deep buffer holds loads made while busy.
module conversor_bcd #(
  parameter logic [3:0] BLANK_CODE = conversor_bcd_pkg::BLANK_CODE_DEF,
  parameter int         STEPS      = conversor_bcd_pkg::N_IN
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] ValorSaida,
  input  logic        EnableOut,
  output logic [3:0]  Digito0,
  output logic [3:0]  Digito1,
  output logic [3:0]  Digito2,
  output logic [3:0]  Digito3,
  output logic        Overflow,
  output logic        Busy,
  output logic        Done
);
  import conversor_bcd_pkg::*;

  state_t                 r_state;
  logic [N_IN-1:0]        r_bin;
  logic [4*N_BCD-1:0]     r_bcd;
  logic                   r_carry;
  logic [5:0]             r_cnt;
  logic                   r_pend;
  logic [N_IN-1:0]        r_pend_val;

  logic [4*N_BCD-1:0]     w_adj;
  logic [4*N_OUT-1:0]     w_out;
  logic                   w_ovf;

  genvar g;
  generate
    for (g = 0; g < N_BCD; g++) begin : g_add3
      bcd_add3 u_add3 (
        .i_dig (r_bcd[4*g +: 4]),
        .o_dig (w_adj[4*g +: 4])
      );
    end
  endgenerate

  // Digits above the displayed four, plus anything shifted out the top, mean overflow.
  assign w_ovf = (|r_bcd[4*N_BCD-1:4*N_OUT]) | r_carry;

  always_comb begin
    w_out = r_bcd[4*N_OUT-1:0];
`ifdef CONVERSOR_BCD_BLANK_EN
    if (r_bcd[15:12] == 4'd0) w_out[15:12] = BLANK_CODE;
    if (r_bcd[15:8]  == 8'd0) w_out[11:8]  = BLANK_CODE;
    if (r_bcd[15:4]  == 12'd0) w_out[7:4]  = BLANK_CODE;
`endif
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state    <= IDLE;
      r_bin      <= '0;
      r_bcd      <= '0;
      r_carry    <= 1'b0;
      r_cnt      <= '0;
      r_pend     <= 1'b0;
      r_pend_val <= '0;
      Digito0    <= BLANK_CODE;
      Digito1    <= BLANK_CODE;
      Digito2    <= BLANK_CODE;
      Digito3    <= BLANK_CODE;
      Overflow   <= 1'b0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (r_state)
        IDLE: begin
          // A fresh strobe is newer than anything pending, so it takes priority.
          if (EnableOut || r_pend) begin
            r_bin   <= EnableOut ? ValorSaida : r_pend_val;
            r_bcd   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_pend  <= 1'b0;
            r_state <= SHIFT;
            Busy    <= 1'b1;
          end
        end
        SHIFT: begin
          r_bcd   <= {w_adj[4*N_BCD-2:0], r_bin[N_IN-1]};
          r_carry <= r_carry | w_adj[4*N_BCD-1];
          r_bin   <= {r_bin[N_IN-2:0], 1'b0};
          r_cnt   <= r_cnt + 6'd1;
          if (r_cnt == 6'(STEPS - 1)) r_state <= DONE;
        end
        DONE: begin
          Digito0  <= w_out[3:0];
          Digito1  <= w_out[7:4];
          Digito2  <= w_out[11:8];
          Digito3  <= w_out[15:12];
          Overflow <= w_ovf;
          Done     <= 1'b1;
          Busy     <= 1'b0;
          r_state  <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          Busy    <= 1'b0;
        end
      endcase

      if (Busy && EnableOut) begin
        r_pend     <= 1'b1;
        r_pend_val <= ValorSaida;
      end
    end
  end
endmodule

// File: tb/tb_conversor_bcd.sv
// Directed bench for conversor_bcd; expectations follow CONVERSOR_BCD_BLANK_EN when defined.
module tb_conversor_bcd;
  logic        Clock;
  logic        Reset;
  logic [31:0] ValorSaida;
  logic        EnableOut;
  logic [3:0]  Digito0, Digito1, Digito2, Digito3;
  logic        Overflow, Busy, Done;

  int n_chk = 0;
  int n_err = 0;
  int n_cyc;
  int n_done;

  conversor_bcd dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .ValorSaida (ValorSaida),
    .EnableOut  (EnableOut),
    .Digito0    (Digito0),
    .Digito1    (Digito1),
    .Digito2    (Digito2),
    .Digito3    (Digito3),
    .Overflow   (Overflow),
    .Busy       (Busy),
    .Done       (Done)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] digs();
    return {Digito3, Digito2, Digito1, Digito0};
  endfunction

  // Called at a negedge; strobe is sampled on the next rising edge.
  task automatic load(input logic [31:0] v);
    ValorSaida = v;
    EnableOut  = 1'b1;
    @(negedge Clock);
    EnableOut  = 1'b0;
  endtask

  // Counts negedges until Done is seen, bounded.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      @(negedge Clock);
      n++;
    end while (!Done && n < 200);
  endtask

  task automatic convert(input string tag, input logic [31:0] v,
                         input logic [15:0] exp_d, input logic exp_o);
    load(v);
    wait_done(n_cyc);
    chk({tag, "_lat"}, n_cyc, 33);
    chk({tag, "_dig"}, digs(), exp_d);
    chk({tag, "_ovf"}, Overflow, exp_o);
    @(negedge Clock);
    chk({tag, "_done1"}, Done, 1'b0);
  endtask

  initial begin
    Reset      = 1'b0;
    EnableOut  = 1'b0;
    ValorSaida = '0;
    repeat (2) @(negedge Clock);
    chk("rst_dig",  digs(), 16'hEEEE);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_ovf",  Overflow, 1'b0);

    // Release and load on the very first edge afterwards.
    Reset = 1'b1;
    ValorSaida = 32'd1234;
    EnableOut  = 1'b1;
    @(negedge Clock);
    EnableOut = 1'b0;
    chk("busy_on", Busy, 1'b1);
    chk("hold_blank", digs(), 16'hEEEE);
    wait_done(n_cyc);
    chk("d1234_lat", n_cyc, 33);
    chk("d1234_dig", digs(), 16'h1234);
    chk("d1234_ovf", Overflow, 1'b0);
    @(negedge Clock);
    chk("d1234_done1", Done, 1'b0);
    chk("idle_busy", Busy, 1'b0);

`ifdef CONVERSOR_BCD_BLANK_EN
    convert("d0", 32'd0, 16'hEEE0, 1'b0);
    convert("d7", 32'd7, 16'hEEE7, 1'b0);
    convert("d305", 32'd305, 16'hE305, 1'b0);
`else
    convert("d0", 32'd0, 16'h0000, 1'b0);
    convert("d7", 32'd7, 16'h0007, 1'b0);
    convert("d305", 32'd305, 16'h0305, 1'b0);
`endif
    convert("d123456", 32'd123456, 16'h3456, 1'b1);
    convert("d10000",  32'd10000,  16'h0000
`ifdef CONVERSOR_BCD_BLANK_EN
                                          | 16'hEEE0
`endif
                                          , 1'b1);
    convert("dmax", 32'hFFFFFFFF, 16'h7295, 1'b1);

    // Pending buffer: 55 then 77 arrive while busy; only 77 survives.
    load(32'd42);
    repeat (9) @(negedge Clock);
    load(32'd55);
    repeat (9) @(negedge Clock);
    load(32'd77);
    wait_done(n_cyc);
    chk("pend_lat1", n_cyc, 13);
    chk("pend_dig1", digs(), 16'h0042
`ifdef CONVERSOR_BCD_BLANK_EN
                             | 16'hEE00
`endif
                             );
    repeat (10) @(negedge Clock);
    chk("pend_busy", Busy, 1'b1);
    chk("pend_hold", digs(), 16'h0042
`ifdef CONVERSOR_BCD_BLANK_EN
                             | 16'hEE00
`endif
                             );
    wait_done(n_cyc);
    chk("pend_lat2", n_cyc, 24);
    chk("pend_dig2", digs(), 16'h0077
`ifdef CONVERSOR_BCD_BLANK_EN
                             | 16'hEE00
`endif
                             );
    repeat (40) @(negedge Clock);
    chk("pend_idle", Busy, 1'b0);

    // Abort mid-conversion with reset.
    convert("pre", 32'hFFFFFFFF, 16'h7295, 1'b1);
    load(32'd9999);
    repeat (15) @(negedge Clock);
    Reset = 1'b0;
    #1;
    chk("abort_dig",  digs(), 16'hEEEE);
    chk("abort_busy", Busy, 1'b0);
    chk("abort_ovf",  Overflow, 1'b0);
    chk("abort_done", Done, 1'b0);
    @(negedge Clock);
    Reset = 1'b1;
    n_done = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clock);
      if (Done) n_done++;
    end
    chk("abort_nodone", n_done, 0);
    chk("abort_idle", Busy, 1'b0);
    convert("d9999", 32'd9999, 16'h9999, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
